cdb_arbiter_rr: RTL and testbench
=================================

# cdb_arbiter_rr

Parametrised common-data-bus arbiter for the Tomasulo core: collects results from N_SRC producers (memory unit, R-type FU, I-type FU, and further FUs), buffers each in a per-source FIFO, and broadcasts at most one result per cycle to the register bank and all reservation stations. It succeeds the fixed two-input CDB arbiter. It adds the following:
- any number of sources;
- per-source queuing with ready/valid backpressure;
- a selectable round-robin or fixed-priority policy.

## Interface
Parameters:
- N_SRC, 3, number of producers (≥1)
- DEPTH, 2, per-source FIFO depth (power of two, ≥2)
- DATA_W, 16, result value width
- REG_AW, 3, destination register address width
- TAG_W, 4, reservation-station tag (Qi) width
- MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- src_valid  in  N_SRC  producer i has a result
- src_ready  out  N_SRC  FIFO i can accept
- src_value  in  N_SRC*DATA_W  result values, source i at bits [i*DATA_W +: DATA_W]
- src_dest  in  N_SRC*REG_AW  destination registers
- src_tag  in  N_SRC*TAG_W  producing tag
- src_wreg  in  N_SRC  1 = result writes register file (0 for stores)
- cdb_valid  out  1  broadcast this cycle (nv_adt)
- cdb_wen  out  1  register-file write enable (habEscr) = cdb_valid & wreg
- cdb_value  out  DATA_W  broadcast value
- cdb_dest  out  REG_AW  broadcast destination
- cdb_tag  out  TAG_W  broadcast tag
- cdb_src  out  SW  granted source index, SW = max(1, clog2(N_SRC))
- occupancy  out  N_SRC*clog2(DEPTH+1)  per-FIFO entry counts

## Operation
- Push: src_valid[i] & src_ready[i] at a rising edge writes {value, dest, tag, wreg} into FIFO i.
- src_ready[i] = !full_i, registered-count based. It is low when full even if that FIFO pops the same cycle; there is no combinational ready-from-pop path.
- Arbitration each cycle over the non-empty FIFOs:
  - MODE 0: search starts at rr_ptr+1 (mod N_SRC) and wraps; the first non-empty FIFO wins; rr_ptr ← winner on grant. rr_ptr is unchanged if nothing is granted.
  - MODE 1: the lowest non-empty index wins; rr_ptr is unused.
- Winner's head is popped and registered onto cdb_* outputs. cdb_valid is high for exactly one cycle per result. There is no consumer backpressure: the broadcast is unconditional.
- Cycle with no non-empty FIFO:
  - cdb_valid = 0 and cdb_wen = 0.
  - cdb_value, cdb_dest, cdb_tag and cdb_src hold their last values.
- Simultaneous push and pop on the same FIFO: both take effect and the count is unchanged.
- Pointer and count arithmetic: modulo DEPTH wrap; count width clog2(DEPTH+1); no overflow is possible given ready gating.
- A push while !src_ready is ignored and is a producer protocol error (assertion in bench).
- Reset (reset_n = 0 at an edge, including mid-operation):
  - all FIFOs flushed and all entries discarded; count = 0;
  - rr_ptr = N_SRC−1, so source 0 is first;
  - all cdb_* = 0, occupancy = 0;
  - src_ready = all ones from the first cycle after the reset edge.

## Timing
- Latency: a result accepted at edge k, with no competition, appears on the CDB in the cycle after edge k+1 (2-edge latency).
- Throughput: one broadcast per cycle aggregate. Under full contention in MODE 0, each source gets one grant per N_SRC cycles.
- Fairness bound (MODE 0): a non-empty FIFO waits at most N_SRC−1 grants.
- MODE 1 gives no starvation guarantee.
- All outputs are registered; no input-to-output combinational path.

## Structure
- Package tomasulo_pkg holds the data-width constants:
  - DATA_W_DEF = 16, REG_AW_DEF = 3, TAG_W_DEF = 4;
  - cdb_entry_t = {wreg, tag, dest, value}.
- Package tomasulo_pkg also holds the arbiter constants MODE_RR = 0 and MODE_FIXED = 1.
- Sub-module cdb_src_fifo:
  - parametrised by DEPTH and the entry width;
  - push/pop/full/empty/count interface;
  - instantiated N_SRC times via generate.
- Arbiter logic (priority rotation, grant, output register) lives in cdb_arbiter_rr itself.

## Test plan
- Reset, then a single push on source 1 (value 0x0042, dest 5, tag 3, wreg 1) → cdb_valid = 1, cdb_wen = 1, cdb_value 0x0042, cdb_dest 5, cdb_tag 3, cdb_src 1 exactly one cycle, 2 edges after the push.
- N_SRC = 3, MODE 0: all three push every cycle → cdb_src sequence 0,1,2,0,1,2…; each src_ready toggles per occupancy; no entry lost or duplicated (scoreboard).
- MODE 1, same stimulus → source 0 always granted while non-empty; source 2 broadcasts only after 0 and 1 drain.
- Fill FIFO 0 to DEPTH with no grants possible (sources 1–2 saturating in MODE 1 with index swap) → src_ready[0] = 0. A further push is not accepted. After one pop, ready returns to 1 the next cycle.
- Store result (wreg = 0, tag 7) → cdb_valid = 1, cdb_wen = 0, tag 7 broadcast.
- Assert reset_n = 0 with FIFOs half full mid-stream → the next cycle has cdb_valid = 0 and occupancy all zero. After release, the first grant goes to source 0 and none of the pre-reset data appears.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo constants: default data-path widths, CDB entry layout and arbiter modes.
package tomasulo_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned REG_AW_DEF = 3;
  localparam int unsigned TAG_W_DEF  = 4;

  localparam int unsigned MODE_RR    = 0;
  localparam int unsigned MODE_FIXED = 1;

  typedef struct packed {
    logic                  wreg;
    logic [TAG_W_DEF-1:0]  tag;
    logic [REG_AW_DEF-1:0] dest;
    logic [DATA_W_DEF-1:0] value;
  } cdb_entry_t;

  // Width of a source index; at least one bit even for a single source.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-producer result queue for the CDB arbiter; power-of-two depth, registered count.
module cdb_src_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 24,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];

  // Pushes into a full queue are dropped rather than overwriting the oldest entry.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_d  = do_push ? wr_q + PW'(1) : wr_q;
    rd_d  = do_pop ? rd_q + PW'(1) : rd_q;
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && do_push) begin
      mem_q[wr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/cdb_arbiter_rr.sv
// Common-data-bus arbiter: queues results per producer and broadcasts one per cycle,
// picking the winner round-robin or by fixed lowest-index priority.
module cdb_arbiter_rr
  import tomasulo_pkg::*;
#(
  parameter int unsigned N_SRC  = 3,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REG_AW = REG_AW_DEF,
  parameter int unsigned TAG_W  = TAG_W_DEF,
  parameter int unsigned MODE   = MODE_RR,
  localparam int unsigned SW    = sel_w(N_SRC),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [N_SRC-1:0]        src_valid,
  output logic [N_SRC-1:0]        src_ready,
  input  logic [N_SRC*DATA_W-1:0] src_value,
  input  logic [N_SRC*REG_AW-1:0] src_dest,
  input  logic [N_SRC*TAG_W-1:0]  src_tag,
  input  logic [N_SRC-1:0]        src_wreg,
  output logic                    cdb_valid,
  output logic                    cdb_wen,
  output logic [DATA_W-1:0]       cdb_value,
  output logic [REG_AW-1:0]       cdb_dest,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [SW-1:0]           cdb_src,
  output logic [N_SRC*CW-1:0]     occupancy
);

  localparam int unsigned EW = 1 + TAG_W + REG_AW + DATA_W;

  logic [EW-1:0]    head [N_SRC];
  logic [N_SRC-1:0] full, empty, pop;
  logic             grant;
  logic [SW-1:0]    win_idx;
  logic [EW-1:0]    win_entry;
  logic [SW-1:0]    rr_q;

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    logic [EW-1:0] wdata;
    assign wdata = {src_wreg[i], src_tag[i*TAG_W +: TAG_W], src_dest[i*REG_AW +: REG_AW],
                    src_value[i*DATA_W +: DATA_W]};

    cdb_src_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
    ) u_fifo (
      .clk_i   (clock),
      .rst_ni  (reset_n),
      .push_i  (src_valid[i]),
      .wdata_i (wdata),
      .pop_i   (pop[i]),
      .rdata_o (head[i]),
      .full_o  (full[i]),
      .empty_o (empty[i]),
      .count_o (occupancy[i*CW +: CW])
    );

    assign src_ready[i] = ~full[i];
  end

  // Round-robin is two ascending passes: first indices above rr_q, then the wrap-around.
  // In fixed mode the first pass already covers every index.
  always_comb begin
    grant     = 1'b0;
    win_idx   = '0;
    win_entry = '0;
    pop       = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (!grant && !empty[i] && (MODE == MODE_FIXED || i > int'(rr_q))) begin
        grant     = 1'b1;
        win_idx   = SW'(i);
        win_entry = head[i];
        pop[i]    = 1'b1;
      end
    end
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (!grant && !empty[i]) begin
        grant     = 1'b1;
        win_idx   = SW'(i);
        win_entry = head[i];
        pop[i]    = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cdb_valid <= 1'b0;
      cdb_wen   <= 1'b0;
      cdb_value <= '0;
      cdb_dest  <= '0;
      cdb_tag   <= '0;
      cdb_src   <= '0;
      rr_q      <= SW'(N_SRC - 1);
    end else begin
      cdb_valid <= grant;
      cdb_wen   <= grant & win_entry[EW-1];
      // Payload and source hold their last values on idle cycles.
      if (grant) begin
        cdb_value <= win_entry[DATA_W-1:0];
        cdb_dest  <= win_entry[DATA_W +: REG_AW];
        cdb_tag   <= win_entry[DATA_W+REG_AW +: TAG_W];
        cdb_src   <= win_idx;
        if (MODE == MODE_RR) begin
          rr_q <= win_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter_rr.sv
// Directed bench for cdb_arbiter_rr: one round-robin and one fixed-priority instance side by side.
module tb_cdb_arbiter_rr;

  logic        clock;
  logic        reset_n;
  logic [2:0]  valid_r, valid_f;
  logic [47:0] value_r, value_f;
  logic [8:0]  dest;
  logic [11:0] tag;
  logic [2:0]  wreg;

  logic [2:0]  ready_r, ready_f;
  logic        cv_r, cv_f, cw_r, cw_f;
  logic [15:0] cval_r, cval_f;
  logic [2:0]  cdst_r, cdst_f;
  logic [3:0]  ctag_r, ctag_f;
  logic [1:0]  csrc_r, csrc_f;
  logic [5:0]  occ_r, occ_f;

  int n_checks = 0;
  int n_errors = 0;

  int exp_rr[10] = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0};
  int exp_fx[10] = '{0, 0, 0, 0, 0, 0, 1, 1, 2, 2};
  int rdy_rr[6]  = '{7, 1, 2, 4, 1, 2};
  int push_r[3], push_f[3], pop_r[3], pop_f[3];

  cdb_arbiter_rr #(.N_SRC(3), .DEPTH(2), .MODE(0)) dut_rr (
    .clock(clock), .reset_n(reset_n), .src_valid(valid_r), .src_ready(ready_r),
    .src_value(value_r), .src_dest(dest), .src_tag(tag), .src_wreg(wreg),
    .cdb_valid(cv_r), .cdb_wen(cw_r), .cdb_value(cval_r), .cdb_dest(cdst_r),
    .cdb_tag(ctag_r), .cdb_src(csrc_r), .occupancy(occ_r)
  );

  cdb_arbiter_rr #(.N_SRC(3), .DEPTH(2), .MODE(1)) dut_fx (
    .clock(clock), .reset_n(reset_n), .src_valid(valid_f), .src_ready(ready_f),
    .src_value(value_f), .src_dest(dest), .src_tag(tag), .src_wreg(wreg),
    .cdb_valid(cv_f), .cdb_wen(cw_f), .cdb_value(cval_f), .cdb_dest(cdst_f),
    .cdb_tag(ctag_f), .cdb_src(csrc_f), .occupancy(occ_f)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    valid_r = '0; valid_f = '0; value_r = '0; value_f = '0;
    dest = '0; tag = '0; wreg = '0;

    // Reset state
    tick; tick;
    chk("rst_ready_r", ready_r, 3'b111);
    chk("rst_ready_f", ready_f, 3'b111);
    chk("rst_valid_r", cv_r, 0);
    chk("rst_occ_r", occ_r, 0);
    chk("rst_src_r", csrc_r, 0);
    chk("rst_value_r", cval_r, 0);
    reset_n = 1'b1;
    tick;

    // Single push on source 1: 2-edge latency, one-cycle broadcast
    valid_r = 3'b010; valid_f = 3'b010;
    value_r[31:16] = 16'h0042; value_f[31:16] = 16'h0042;
    dest[5:3] = 3'd5; tag[7:4] = 4'd3; wreg = 3'b010;
    tick;
    valid_r = '0; valid_f = '0;
    chk("lat_valid_early", cv_r, 0);
    chk("lat_occ", occ_r, 6'h04);
    tick;
    chk("one_valid", cv_r, 1);
    chk("one_wen", cw_r, 1);
    chk("one_value", cval_r, 16'h0042);
    chk("one_dest", cdst_r, 5);
    chk("one_tag", ctag_r, 3);
    chk("one_src", csrc_r, 1);
    chk("one_src_f", csrc_f, 1);
    chk("one_occ", occ_r, 0);
    tick;
    chk("one_valid_drop", cv_r, 0);
    chk("one_wen_drop", cw_r, 0);
    chk("hold_value", cval_r, 16'h0042);
    chk("hold_src", csrc_r, 1);

    // Store result: broadcast without register write
    valid_r = 3'b100; valid_f = 3'b100;
    value_r[47:32] = 16'h0099; value_f[47:32] = 16'h0099;
    dest[8:6] = 3'd0; tag[11:8] = 4'd7; wreg = 3'b000;
    tick;
    valid_r = '0; valid_f = '0;
    tick;
    chk("st_valid", cv_r, 1);
    chk("st_wen", cw_r, 0);
    chk("st_tag", ctag_r, 7);
    chk("st_src", csrc_r, 2);
    chk("st_value", cval_r, 16'h0099);
    chk("st_wen_f", cw_f, 0);
    tick;

    // Full contention: every source pushes whenever ready for six edges, then drains
    dest = '0; tag = '0; wreg = 3'b111;
    for (int s = 0; s < 3; s++) begin
      push_r[s] = 0; push_f[s] = 0; pop_r[s] = 0; pop_f[s] = 0;
    end
    for (int e = 1; e <= 12; e++) begin
      for (int s = 0; s < 3; s++) begin
        valid_r[s] = (e <= 6) && ready_r[s];
        valid_f[s] = (e <= 6) && ready_f[s];
        value_r[s*16 +: 16] = 16'(s * 256 + push_r[s]);
        value_f[s*16 +: 16] = 16'(s * 256 + push_f[s]);
      end
      tick;
      for (int s = 0; s < 3; s++) begin
        if (valid_r[s]) push_r[s]++;
        if (valid_f[s]) push_f[s]++;
      end
      if (e >= 2 && e <= 11) begin
        chk("rr_valid", cv_r, 1);
        chk("rr_src", csrc_r, exp_rr[e-2]);
        chk("rr_value", cval_r, 16'(exp_rr[e-2] * 256 + pop_r[exp_rr[e-2]]));
        pop_r[exp_rr[e-2]]++;
        chk("fx_valid", cv_f, 1);
        chk("fx_src", csrc_f, exp_fx[e-2]);
        chk("fx_value", cval_f, 16'(exp_fx[e-2] * 256 + pop_f[exp_fx[e-2]]));
        pop_f[exp_fx[e-2]]++;
      end else if (e == 12) begin
        chk("rr_idle", cv_r, 0);
        chk("fx_idle", cv_f, 0);
      end
      if (e <= 6) chk("rr_ready", ready_r, rdy_rr[e-1]);
    end
    valid_r = '0; valid_f = '0;
    chk("rr_drained", occ_r, 0);
    chk("fx_drained", occ_f, 0);

    // Fixed priority: source 0 saturates so FIFO 2 fills; an extra push is dropped
    valid_f = 3'b101; value_f[15:0] = 16'h0A00; value_f[47:32] = 16'h0B00;
    tick;
    chk("fill_ready1", ready_f, 3'b111);
    chk("fill_occ1", occ_f, 6'h11);
    value_f[15:0] = 16'h0A01; value_f[47:32] = 16'h0B01;
    tick;
    chk("fill_ready2", ready_f, 3'b011);
    chk("fill_occ2", occ_f, 6'h21);
    chk("fill_value2", cval_f, 16'h0A00);
    chk("fill_src2", csrc_f, 0);
    value_f[15:0] = 16'h0A02; value_f[47:32] = 16'hDEAD;
    tick;
    chk("full_occ", occ_f, 6'h21);
    chk("full_ready", ready_f, 3'b011);
    chk("full_value", cval_f, 16'h0A01);
    valid_f = '0;
    tick;
    chk("drain0_value", cval_f, 16'h0A02);
    chk("drain0_occ", occ_f, 6'h20);
    chk("drain0_ready", ready_f, 3'b011);
    tick;
    chk("pop2_src", csrc_f, 2);
    chk("pop2_value", cval_f, 16'h0B00);
    chk("pop2_ready", ready_f, 3'b111);
    chk("pop2_occ", occ_f, 6'h10);
    tick;
    chk("pop2b_value", cval_f, 16'h0B01);
    chk("pop2b_occ", occ_f, 0);
    tick;
    chk("nodead_valid", cv_f, 0);
    chk("nodead_value", cval_f, 16'h0B01);

    // Reset mid-stream with FIFOs partly full
    valid_r = 3'b111; valid_f = 3'b111;
    value_r = {16'h0502, 16'h0501, 16'h0500}; value_f = value_r;
    tick; tick;
    valid_r = '0; valid_f = '0;
    reset_n = 1'b0;
    tick;
    chk("mrst_valid_r", cv_r, 0);
    chk("mrst_valid_f", cv_f, 0);
    chk("mrst_occ_r", occ_r, 0);
    chk("mrst_occ_f", occ_f, 0);
    chk("mrst_ready_r", ready_r, 3'b111);
    chk("mrst_value_r", cval_r, 0);
    reset_n = 1'b1;
    valid_r = 3'b111; valid_f = 3'b111;
    value_r = {16'h0C02, 16'h0C01, 16'h0C00}; value_f = value_r;
    tick;
    valid_r = '0; valid_f = '0;
    chk("post_valid", cv_r, 0);
    chk("post_occ", occ_r, 6'h15);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("post_src_r", csrc_r, k);
      chk("post_value_r", cval_r, 16'(16'h0C00 + k));
      chk("post_src_f", csrc_f, k);
      chk("post_value_f", cval_f, 16'(16'h0C00 + k));
    end
    tick;
    chk("post_idle_r", cv_r, 0);
    chk("post_idle_f", cv_f, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
